psum_output_buffer: RTL
=======================

Name: psum_output_buffer

Overview:
- Partial-sum storage stage directly downstream of ConvolutionalUnit.
- Captures partialSumOut lanes per output address and returns stored sums on a read port that drives ConvolutionalUnit.partialSumIn on the next kernel pass.
- On the final pass, applies optional ReLU and pushes the finished vector into a small output FIFO with a valid/ready handshake.
- Includes a sequential clear engine that zeroes all storage.

Parameters:
- depth, 2: log2 of lane count.
- D, 1<<depth: lanes per vector.
- A, 7: storage address width; 2^A entries, each D*W bits.
- W, 16: lane width, two's complement.
- F, 4: output FIFO depth in entries, power of two, at least 2.

Ports:
- CLK, input, 1: sole clock; all state updates on rising edge.
- RST, input, 1: synchronous, active-high reset.
- clrStart, input, 1: pulse that starts a full storage clear.
- busy, output, 1: high while a clear is in progress.
- wrEn, input, 1: write request.
- wrAddr, input, A: write address.
- wrData, input, W*D: from ConvolutionalUnit.partialSumOut; lane i = bits [W*i+W-1 : W*i].
- wrLast, input, 1: qualifies wrEn; this is the final pass for wrAddr.
- reluEn, input, 1: sampled with a wrLast write; zero negative lanes.
- wrReady, output, 1: write accepted when wrEn && wrReady.
- rdEn, input, 1: read request.
- rdAddr, input, A: read address.
- psumOut, output, W*D: read data to ConvolutionalUnit.partialSumIn.
- outValid, output, 1: FIFO head valid.
- outReady, input, 1: consumer ready.
- outData, output, W*D: finished, activated vector.
- outAddr, output, A: address of outData.

Behaviour:
- Reset:
  - FSM enters CLEAR with the clear counter at 0.
  - busy=1, wrReady=0, psumOut=0, outValid=0, outData=0, outAddr=0.
  - FIFO is emptied.
- FSM states: CLEAR and IDLE.
  - CLEAR: writes zero to entry counter, counter+1 each cycle. After writing entry 2^A-1, transitions to IDLE.
  - CLEAR lasts exactly 2^A cycles.
  - IDLE -> CLEAR on clrStart. clrStart during CLEAR restarts the counter at 0.
  - RST mid-clear restarts CLEAR from 0.
- busy = (state==CLEAR).
- wrReady = (state==IDLE) && !(wrLast-path FIFO full).
  - Precisely: wrReady = IDLE && (FIFO count < F, or a pop occurs this cycle).
  - wrReady is the same for wrLast and non-last writes, so it is combinational from state and FIFO status only, never from wrEn.
- Write, on accepted wrEn:
  - mem[wrAddr] <= wrData.
  - If wrLast: also push {wrAddr, act(wrData)} into the FIFO.
  - act(): per lane, if reluEn and the lane MSB=1, the lane becomes 0; otherwise unchanged. No width growth.
  - Storage always receives the raw (non-ReLU) data.
- Read, 1-cycle latency:
  - rdEn in cycle n gives psumOut = mem[rdAddr] in cycle n+1.
  - Without rdEn, psumOut holds its last value.
- Same-cycle hazard: accepted write and rdEn to the same address in the same cycle -> psumOut returns the new wrData (write-first bypass).
- During CLEAR: rdEn is ignored and psumOut is forced to 0 the following cycle. Writes are not accepted.
- FIFO, first-in first-out:
  - outValid = count>0. outData/outAddr show the head.
  - Pop on outValid && outReady.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Pop when empty has no effect.
  - FIFO contents are unaffected by clrStart; only RST empties the FIFO.
- outData/outAddr are stable while outValid && !outReady.

Test Plan (D=4, W=16, A=7, F=4):
- Reset:
  - Assert RST 1 cycle, then release.
  - Required: busy=1 for exactly 128 cycles, then busy=0 and wrReady=1.
  - rdEn to address 5 afterwards -> psumOut=0.
- Write/read:
  - Write wrAddr=3, wrData={16'h0004,16'h0003,16'h0002,16'h0001}, wrLast=0.
  - Next cycle, rdEn rdAddr=3 -> psumOut equals that vector one cycle later; outValid stays 0.
- Same-cycle bypass:
  - Write addr 9 = 64'h1111_2222_3333_4444 together with rdEn addr 9.
  - Required: psumOut=64'h1111_2222_3333_4444 next cycle.
- ReLU final pass:
  - wrLast=1, reluEn=1, addr 7, lanes {-5,10,-1,0} (16'hFFFB,16'h000A,16'hFFFF,0).
  - Required: outValid=1, outData lanes {0,10,0,0}, outAddr=7.
  - Read addr 7 -> raw {-5,10,-1,0}.
- Backpressure:
  - outReady=0; issue 4 wrLast writes to addresses 1..4. wrReady drops to 0 after the 4th.
  - A 5th write is held and not stored.
  - Raise outReady: outAddr sequence 1,2,3,4. wrReady returns to 1 the cycle the first pop occurs.
- Clear mid-operation:
  - clrStart while the FIFO holds 2 entries -> busy for 128 cycles; FIFO still presents both entries.
  - Reads of previously written addresses return 0 after the clear.
  - RST asserted at clear cycle 50 restarts a full 128-cycle clear and empties the FIFO.

Source files
------------

// File: rtl/psum_output_buffer_if.sv
// Bus bundle for psum_output_buffer. It carries the clear, write, read and output-FIFO signals.
// slave  : the view of the buffer (DUT).
// master : the view of the driver (ConvolutionalUnit side / testbench).
interface psum_output_buffer_if #(
    parameter int unsigned A = 7,
    parameter int unsigned W = 16,
    parameter int unsigned D = 4
);
    logic             clrStart;
    logic             busy;
    logic             wrEn;
    logic [A-1:0]     wrAddr;
    logic [W*D-1:0]   wrData;
    logic             wrLast;
    logic             reluEn;
    logic             wrReady;
    logic             rdEn;
    logic [A-1:0]     rdAddr;
    logic [W*D-1:0]   psumOut;
    logic             outValid;
    logic             outReady;
    logic [W*D-1:0]   outData;
    logic [A-1:0]     outAddr;

    modport slave (
        input  clrStart, wrEn, wrAddr, wrData, wrLast, reluEn, rdEn, rdAddr, outReady,
        output busy, wrReady, psumOut, outValid, outData, outAddr
    );

    modport master (
        output clrStart, wrEn, wrAddr, wrData, wrLast, reluEn, rdEn, rdAddr, outReady,
        input  busy, wrReady, psumOut, outValid, outData, outAddr
    );
endinterface

// File: rtl/psum_output_buffer.sv
// Partial-sum storage downstream of ConvolutionalUnit.
// Stores one D-lane vector per address, returns stored sums with 1-cycle read latency
// (write-first bypass on a same-address hazard), pushes final-pass vectors (optional ReLU)
// into an F-entry output FIFO, and zeroes all storage with a sequential clear engine.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : psum_output_buffer_if.slave (clear, write, read, output FIFO handshake)
module psum_output_buffer #(
    parameter int unsigned depth = 2,
    parameter int unsigned A     = 7,
    parameter int unsigned W     = 16,
    parameter int unsigned F     = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    psum_output_buffer_if.slave   bus
);
    localparam int unsigned D  = 1 << depth;
    localparam int unsigned DW = D * W;
    localparam int unsigned N  = 1 << A;
    localparam int unsigned PW = (F > 1) ? $clog2(F) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [A-1:0]    r_clr_cnt;
    logic [A-1:0]    w_clr_cnt_nxt;

    logic [DW-1:0]   r_mem [N];
    logic [DW-1:0]   r_psum;

    logic [DW-1:0]   r_fifo_data [F];
    logic [A-1:0]    r_fifo_addr [F];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;

    logic            w_pop;
    logic            w_wr_ready;
    logic            w_wr_acc;
    logic            w_push;
    logic [DW-1:0]   w_act;

    // Per-lane ReLU: negative lanes become zero, width unchanged
    function automatic logic [DW-1:0] f_act(input logic [DW-1:0] v, input logic relu);
        logic [DW-1:0] r;
        r = v;
        for (int i = 0; i < int'(D); i++) begin
            if (relu && v[W*i+W-1]) begin
                r[W*i +: W] = '0;
            end
        end
        return r;
    endfunction

    // Clear/idle state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next state: sweep every entry once; clrStart always restarts from entry 0
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + A'(1);
                if (r_clr_cnt == A'(N - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE:  w_clr_cnt_nxt = '0;
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
        if (bus.clrStart) begin
            w_state_nxt   = S_CLEAR;
            w_clr_cnt_nxt = '0;
        end
    end

    // Handshake decode; wrReady never depends on wrEn
    assign w_pop      = (r_cnt != '0) && bus.outReady;
    assign w_wr_ready = (r_state == S_IDLE) && ((r_cnt < CW'(F)) || w_pop);
    assign w_wr_acc   = bus.wrEn && w_wr_ready && !RST;
    assign w_push     = w_wr_acc && bus.wrLast;
    assign w_act      = f_act(bus.wrData, bus.reluEn);

    assign bus.busy     = (r_state == S_CLEAR);
    assign bus.wrReady  = w_wr_ready;
    assign bus.psumOut  = r_psum;
    assign bus.outValid = (r_cnt != '0);
    assign bus.outData  = r_fifo_data[r_rp];
    assign bus.outAddr  = r_fifo_addr[r_rp];

    // Storage: clear engine owns the write port while clearing; raw data stored otherwise
    always_ff @(posedge CLK) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            r_mem[bus.wrAddr] <= bus.wrData;
        end
    end

    // Read port with write-first bypass; forced to zero while clearing
    always_ff @(posedge CLK) begin
        if (RST || (r_state == S_CLEAR)) begin
            r_psum <= '0;
        end else if (bus.rdEn) begin
            if (w_wr_acc && (bus.wrAddr == bus.rdAddr)) begin
                r_psum <= bus.wrData;
            end else begin
                r_psum <= r_mem[bus.rdAddr];
            end
        end
    end

    // Output FIFO; only RST empties it, clrStart leaves it alone
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < int'(F); i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wp] <= w_act;
                r_fifo_addr[r_wp] <= bus.wrAddr;
                r_wp              <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule
